// File: rtl/sad_disparity_search.sv
`default_nettype none
//============================================================================
// Module   : sad_disparity_search
// Brief    : Streams WIN window rows per candidate disparity, accumulates a
//            WIN x WIN sum of absolute differences per candidate and reports
//            the lowest-SAD disparity (plus tie flag) on a valid/ready port.
// Revision : 1.0 - initial release
//============================================================================
module sad_disparity_search #(
    parameter int WIN       = 15,
    parameter int DATA_SIZE = 8,
    parameter int MAX_DISP  = 64,
    localparam int ROW_W    = $clog2(WIN * ((1 << DATA_SIZE) - 1) + 1),
    localparam int SAD_SIZE = $clog2(WIN * WIN * ((1 << DATA_SIZE) - 1) + 1),
    localparam int DISP_W   = ($clog2(MAX_DISP) > 1) ? $clog2(MAX_DISP) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIN*DATA_SIZE-1:0]  in_a,
    input  logic [WIN*DATA_SIZE-1:0]  in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DISP_W-1:0]         out_disp,
    output logic [SAD_SIZE-1:0]       out_sad,
    output logic                      out_tie
);

    localparam int c_ROW_CW = ($clog2(WIN) > 1) ? $clog2(WIN) : 1;

    localparam logic [c_ROW_CW-1:0] c_ROW_LAST  = c_ROW_CW'(WIN - 1);
    localparam logic [DISP_W-1:0]   c_DISP_LAST = DISP_W'(MAX_DISP - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic [c_ROW_CW-1:0] r_row_cnt;
    logic [DISP_W-1:0]   r_disp_cnt;
    logic [SAD_SIZE-1:0] r_acc;

    logic [SAD_SIZE-1:0] r_best_sad;
    logic [DISP_W-1:0]   r_best_disp;
    logic                r_best_tie;

    logic [SAD_SIZE-1:0] r_out_sad;
    logic [DISP_W-1:0]   r_out_disp;
    logic                r_out_tie;

    logic [DATA_SIZE-1:0] w_diff [WIN];
    logic [ROW_W-1:0]     w_row_sad;
    logic [SAD_SIZE-1:0]  w_cand;
    logic                 w_accept;
    logic                 w_last_row;
    logic                 w_last_disp;
    logic                 w_final_beat;

    logic [SAD_SIZE-1:0]  w_best_sad_nxt;
    logic [DISP_W-1:0]    w_best_disp_nxt;
    logic                 w_best_tie_nxt;

    // Per-pixel absolute difference; the larger operand is always the minuend
    generate
        for (genvar i = 0; i < WIN; i++) begin : g_abs
            logic [DATA_SIZE-1:0] w_pa;
            logic [DATA_SIZE-1:0] w_pb;
            assign w_pa      = in_a[DATA_SIZE*i +: DATA_SIZE];
            assign w_pb      = in_b[DATA_SIZE*i +: DATA_SIZE];
            assign w_diff[i] = (w_pa > w_pb) ? (w_pa - w_pb) : (w_pb - w_pa);
        end
    endgenerate

    // Row SAD: ROW_W is sized so this sum can never overflow
    always_comb begin
        w_row_sad = '0;
        for (int i = 0; i < WIN; i++) begin
            w_row_sad = w_row_sad + ROW_W'(w_diff[i]);
        end
    end

    assign w_accept     = in_valid && in_ready;
    assign w_last_row   = (r_row_cnt == c_ROW_LAST);
    assign w_last_disp  = (r_disp_cnt == c_DISP_LAST);
    assign w_final_beat = w_accept && w_last_row && w_last_disp;
    assign w_cand       = r_acc + SAD_SIZE'(w_row_sad);

    // Best-candidate update; on equality the earlier (lower) disparity is kept
    always_comb begin
        w_best_sad_nxt  = r_best_sad;
        w_best_disp_nxt = r_best_disp;
        w_best_tie_nxt  = r_best_tie;
        if (r_disp_cnt == '0) begin
            w_best_sad_nxt  = w_cand;
            w_best_disp_nxt = '0;
            w_best_tie_nxt  = 1'b0;
        end else if (w_cand < r_best_sad) begin
            w_best_sad_nxt  = w_cand;
            w_best_disp_nxt = r_disp_cnt;
            w_best_tie_nxt  = 1'b0;
        end else if (w_cand == r_best_sad) begin
            w_best_tie_nxt  = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a 1x1 search can jump from IDLE straight to HOLD
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_final_beat) begin
                    w_state_nxt = c_HOLD;
                end else if (w_accept) begin
                    w_state_nxt = c_ACCUM;
                end
            end
            c_ACCUM: begin
                if (w_final_beat) begin
                    w_state_nxt = c_HOLD;
                end
            end
            c_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake outputs; in_ready is forced low while reset is asserted
    always_comb begin
        in_ready  = !rst && (r_state != c_HOLD);
        out_valid = (r_state == c_HOLD);
    end

    // Counters, accumulator, running best and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt   <= '0;
            r_disp_cnt  <= '0;
            r_acc       <= '0;
            r_best_sad  <= '0;
            r_best_disp <= '0;
            r_best_tie  <= 1'b0;
            r_out_sad   <= '0;
            r_out_disp  <= '0;
            r_out_tie   <= 1'b0;
        end else if (w_accept) begin
            if (w_last_row) begin
                r_acc       <= '0;
                r_row_cnt   <= '0;
                r_best_sad  <= w_best_sad_nxt;
                r_best_disp <= w_best_disp_nxt;
                r_best_tie  <= w_best_tie_nxt;
                if (w_last_disp) begin
                    r_disp_cnt <= '0;
                    r_out_sad  <= w_best_sad_nxt;
                    r_out_disp <= w_best_disp_nxt;
                    r_out_tie  <= w_best_tie_nxt;
                end else begin
                    r_disp_cnt <= r_disp_cnt + DISP_W'(1);
                end
            end else begin
                r_acc     <= w_cand;
                r_row_cnt <= r_row_cnt + c_ROW_CW'(1);
            end
        end
    end

    assign out_sad  = r_out_sad;
    assign out_disp = r_out_disp;
    assign out_tie  = r_out_tie;

endmodule
`default_nettype wire

// File: tb/tb_sad_disparity_search.sv
`default_nettype none
//============================================================================
// Module   : tb_sad_disparity_search
// Brief    : Directed self-checking bench for sad_disparity_search: a 3x3 /
//            4-disparity instance and a full-width 15x15 / 1-disparity one.
// Revision : 1.0 - initial release
//============================================================================
module tb_sad_disparity_search;

    logic clk;
    logic rst;

    // Small instance: WIN=3, MAX_DISP=4
    logic        s_in_valid;
    logic        s_in_ready;
    logic [23:0] s_in_a;
    logic [23:0] s_in_b;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [1:0]  s_out_disp;
    logic [11:0] s_out_sad;
    logic        s_out_tie;

    // Wide instance: WIN=15, MAX_DISP=1
    logic         w_in_valid;
    logic         w_in_ready;
    logic [119:0] w_in_a;
    logic [119:0] w_in_b;
    logic         w_out_valid;
    logic         w_out_ready;
    logic [0:0]   w_out_disp;
    logic [15:0]  w_out_sad;
    logic         w_out_tie;

    int n_pass;
    int n_total;

    sad_disparity_search #(.WIN(3), .DATA_SIZE(8), .MAX_DISP(4)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_disp  (s_out_disp),
        .out_sad   (s_out_sad),
        .out_tie   (s_out_tie)
    );

    sad_disparity_search #(.WIN(15), .DATA_SIZE(8), .MAX_DISP(1)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_a      (w_in_a),
        .in_b      (w_in_b),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_disp  (w_out_disp),
        .out_sad   (w_out_sad),
        .out_tie   (w_out_tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // One beat on the small instance, consumed on the next rising edge
    task automatic s_beat(input logic [7:0] av, input logic [7:0] bv);
        s_in_valid = 1'b1;
        s_in_a     = {3{av}};
        s_in_b     = {3{bv}};
        check("s_beat_ready", 32'(s_in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // Full 12-beat search, a = 10 everywhere, b constant per disparity
    task automatic s_search(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] bs [4];
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 3; r++) begin
                if (d == 3 && r == 2) check("s_pre_valid", 32'(s_out_valid), 32'd0);
                s_beat(8'd10, bs[d]);
            end
        end
        s_in_valid = 1'b0;
        check("s_valid_latency", 32'(s_out_valid), 32'd1);
    endtask

    task automatic s_release();
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        check("s_release_valid", 32'(s_out_valid), 32'd0);
        check("s_release_ready", 32'(s_in_ready), 32'd1);
    endtask

    // Full 15-beat search on the wide instance
    task automatic w_search(input logic [7:0] av, input logic [7:0] bv);
        for (int r = 0; r < 15; r++) begin
            w_in_valid = 1'b1;
            w_in_a     = {15{av}};
            w_in_b     = {15{bv}};
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        check("w_valid", 32'(w_out_valid), 32'd1);
        check("w_sad", 32'(w_out_sad), 32'd57375);
        check("w_disp", 32'(w_out_disp), 32'd0);
        check("w_tie", 32'(w_out_tie), 32'd0);
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        check("w_release_valid", 32'(w_out_valid), 32'd0);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b1;
        s_in_valid  = 1'b1;
        s_in_a      = '0;
        s_in_b      = {3{8'hFF}};
        s_out_ready = 1'b0;
        w_in_valid  = 1'b0;
        w_in_a      = '0;
        w_in_b      = '0;
        w_out_ready = 1'b0;

        // Reset held 3 cycles with a beat offered
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_in_ready", 32'(s_in_ready), 32'd0);
        end
        rst        = 1'b0;
        s_in_valid = 1'b0;
        #1;
        check("rst_rel_in_ready", 32'(s_in_ready), 32'd1);
        check("rst_out_valid", 32'(s_out_valid), 32'd0);
        check("rst_out_disp", 32'(s_out_disp), 32'd0);
        check("rst_out_sad", 32'(s_out_sad), 32'd0);
        check("rst_out_tie", 32'(s_out_tie), 32'd0);
        check("rst_w_out_valid", 32'(w_out_valid), 32'd0);
        @(posedge clk); #1;

        // Minimum search: SADs 36, 18, 9, 27
        s_search(8'd14, 8'd12, 8'd11, 8'd13);
        check("min_disp", 32'(s_out_disp), 32'd2);
        check("min_sad", 32'(s_out_sad), 32'd9);
        check("min_tie", 32'(s_out_tie), 32'd0);

        // Backpressure: result held, offered beats ignored
        s_in_valid = 1'b1;
        s_in_a     = {3{8'hFF}};
        s_in_b     = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", 32'(s_in_ready), 32'd0);
            check("bp_out_valid", 32'(s_out_valid), 32'd1);
            check("bp_out_disp", 32'(s_out_disp), 32'd2);
            check("bp_out_sad", 32'(s_out_sad), 32'd9);
            check("bp_out_tie", 32'(s_out_tie), 32'd0);
        end
        s_in_valid = 1'b0;
        s_release();

        // Tie search: SADs 27, 9, 18, 9
        s_search(8'd13, 8'd11, 8'd12, 8'd11);
        check("tie_disp", 32'(s_out_disp), 32'd1);
        check("tie_sad", 32'(s_out_sad), 32'd9);
        check("tie_tie", 32'(s_out_tie), 32'd1);
        s_release();

        // Reset after 5 beats, then a clean minimum search
        for (int i = 0; i < 5; i++) s_beat(8'd0, 8'd255);
        s_in_valid = 1'b0;
        rst        = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_in_ready", 32'(s_in_ready), 32'd0);
        rst = 1'b0;
        #1;
        s_search(8'd14, 8'd12, 8'd11, 8'd13);
        check("mid_disp", 32'(s_out_disp), 32'd2);
        check("mid_sad", 32'(s_out_sad), 32'd9);
        check("mid_tie", 32'(s_out_tie), 32'd0);
        s_release();

        // Full-scale difference, both operand orders
        w_search(8'hFF, 8'h00);
        w_search(8'h00, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
